k_alu_arbiter: RTL and testbench

//  Shares one K_ALU instance between NREQ requesters, e.g. main datapath and address/branch unit.

---
 rtl/k_alu_pkg.sv | 22 ++
 rtl/k_alu_arbiter_if.sv | 31 +++
 rtl/k_alu.sv | 31 +++
 rtl/k_rr_arbiter.sv | 47 ++++
 rtl/k_alu_arbiter.sv | 142 ++++++++++++++
 tb/tb_k_alu_arbiter.sv | 241 ++++++++++++++++++++++++
 6 files changed

// File: rtl/k_alu_pkg.sv
// Shared ALU definitions: control codes understood by K_ALU and a legality check
// that the decode control also reuses.
package k_alu_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_SLL = 4'b1000;

   // True for every control code K_ALU actually implements.
   function automatic logic is_legal_op(input logic [3:0] op);
      logic legal;
      case (op)
         ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLL: legal = 1'b1;
         default:                                            legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/k_alu_arbiter_if.sv
// Requester/consumer bundle of the shared ALU arbiter. Per-requester fields are
// packed side by side; requester i owns slice [width*i +: width].
interface k_alu_arbiter_if #(
   parameter int NREQ = 2,
   parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
);

   logic [NREQ-1:0]    K_req;
   logic [4*NREQ-1:0]  K_op;
   logic [32*NREQ-1:0] K_a;
   logic [32*NREQ-1:0] K_b;
   logic [5*NREQ-1:0]  K_shamt;
   logic [NREQ-1:0]    K_gnt;
   logic               K_resp_valid;
   logic               K_resp_ready;
   logic [IDW-1:0]     K_resp_id;
   logic [31:0]        K_resp_result;
   logic               K_resp_zero;
   logic               K_resp_err;

   modport master (
      output K_req, K_op, K_a, K_b, K_shamt, K_resp_ready,
      input  K_gnt, K_resp_valid, K_resp_id, K_resp_result, K_resp_zero, K_resp_err
   );

   modport slave (
      input  K_req, K_op, K_a, K_b, K_shamt, K_resp_ready,
      output K_gnt, K_resp_valid, K_resp_id, K_resp_result, K_resp_zero, K_resp_err
   );

endinterface

// File: rtl/k_alu.sv
// Shared 32-bit ALU. Purely combinational; the arbiter decides when its
// inputs change and when its result is captured.
module k_alu
   import k_alu_pkg::*;
#(
   parameter int W = 32
) (
   input  logic [3:0]   K_ALU_control,
   input  logic [W-1:0] K_in1,
   input  logic [W-1:0] K_in2,
   input  logic [4:0]   shamt,
   output logic [W-1:0] K_result,
   output logic         K_zero
);

   // Evaluate the selected operation; SLT compares unsigned, SLL shifts operand 2.
   always_comb begin
      K_result = '0;
      case (K_ALU_control)
         ALU_AND: K_result = K_in1 & K_in2;
         ALU_OR:  K_result = K_in1 | K_in2;
         ALU_ADD: K_result = K_in1 + K_in2;
         ALU_SUB: K_result = K_in1 - K_in2;
         ALU_SLT: K_result = {{(W-1){1'b0}}, (K_in1 < K_in2)};
         ALU_SLL: K_result = K_in2 << shamt;
         default: K_result = '0;
      endcase
      K_zero = (K_result == '0);
   end

endmodule

// File: rtl/k_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer,
// wrapping cyclically, and moves the pointer past the winner once the grant is used.
module k_rr_arbiter #(
   parameter int NREQ = 2,
   parameter int IDW  = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NREQ-1:0] req,
   input  logic            enable,
   input  logic            advance,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  gnt_idx
);

   logic [IDW-1:0] ptr_q;

   // Scan requesters starting at the pointer and pick the first one asking.
   always_comb begin
      int  idx;
      logic found;
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (enable && !found && req[idx]) begin
            gnt[idx] = 1'b1;
            gnt_idx  = IDW'(idx);
            found    = 1'b1;
         end
      end
   end

   // After a used grant, the winner becomes lowest priority next time.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q <= '0;
      end else if (advance) begin
         if (gnt_idx == IDW'(NREQ - 1)) ptr_q <= '0;
         else                           ptr_q <= gnt_idx + IDW'(1);
      end
   end

endmodule

// File: rtl/k_alu_arbiter.sv
// Shares the single K_ALU between NREQ requesters: round-robin grant, one issue
// per cycle, tagged response one cycle later with ready/valid backpressure.
module k_alu_arbiter
   import k_alu_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int W    = 32
) (
   input  logic            K_clk,
   input  logic            K_reset,
   k_alu_arbiter_if.slave  bus
);

   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0] gnt;
   logic [IDW-1:0]  gnt_idx;
   logic            stage_free;
   logic            arb_enable;
   logic            issue;
   logic            issue_legal;

   logic [3:0]      sel_op;
   logic [W-1:0]    sel_a;
   logic [W-1:0]    sel_b;
   logic [4:0]      sel_shamt;

   logic [3:0]      alu_ctrl, ctrl_q;
   logic [W-1:0]    alu_in1, in1_q;
   logic [W-1:0]    alu_in2, in2_q;
   logic [4:0]      alu_shamt, shamt_q;
   logic [W-1:0]    alu_result;
   logic            alu_zero;

   logic            valid_q;
   logic [IDW-1:0]  id_q;
   logic [W-1:0]    result_q;
   logic            zero_q;
   logic            err_q;

   assign stage_free  = !valid_q || bus.K_resp_ready;
   assign arb_enable  = stage_free && !K_reset;
   assign issue       = |gnt;
   assign issue_legal = issue && is_legal_op(sel_op);

   k_rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_rr (
      .clk     (K_clk),
      .reset   (K_reset),
      .req     (bus.K_req),
      .enable  (arb_enable),
      .advance (issue),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   // Pull the granted requester's fields out of the packed buses (grant is one-hot).
   always_comb begin
      sel_op    = '0;
      sel_a     = '0;
      sel_b     = '0;
      sel_shamt = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            sel_op    = sel_op    | bus.K_op[4*i +: 4];
            sel_a     = sel_a     | bus.K_a[32*i +: 32];
            sel_b     = sel_b     | bus.K_b[32*i +: 32];
            sel_shamt = sel_shamt | bus.K_shamt[5*i +: 5];
         end
      end
   end

   // ALU sees fresh operands only on a legal issue; SLL routes shamt into operand 1
   // so a shamt-only change still alters an evaluated input.
   always_comb begin
      alu_ctrl  = ctrl_q;
      alu_in1   = in1_q;
      alu_in2   = in2_q;
      alu_shamt = shamt_q;
      if (issue_legal) begin
         alu_ctrl  = sel_op;
         alu_in1   = (sel_op == ALU_SLL) ? {{(W-5){1'b0}}, sel_shamt} : sel_a;
         alu_in2   = sel_b;
         alu_shamt = sel_shamt;
      end
   end

   // Remember the last operands so idle cycles leave the ALU inputs untouched.
   always_ff @(posedge K_clk) begin
      if (K_reset) begin
         ctrl_q  <= '0;
         in1_q   <= '0;
         in2_q   <= '0;
         shamt_q <= '0;
      end else if (issue_legal) begin
         ctrl_q  <= alu_ctrl;
         in1_q   <= alu_in1;
         in2_q   <= alu_in2;
         shamt_q <= alu_shamt;
      end
   end

   k_alu #(
      .W (W)
   ) K_ALU (
      .K_ALU_control (alu_ctrl),
      .K_in1         (alu_in1),
      .K_in2         (alu_in2),
      .shamt         (alu_shamt),
      .K_result      (alu_result),
      .K_zero        (alu_zero)
   );

   // Response stage: load on issue, drop valid on consume, hold everything under backpressure.
   always_ff @(posedge K_clk) begin
      if (K_reset) begin
         valid_q  <= 1'b0;
         id_q     <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
         err_q    <= 1'b0;
      end else if (issue) begin
         valid_q  <= 1'b1;
         id_q     <= gnt_idx;
         err_q    <= !issue_legal;
         result_q <= issue_legal ? alu_result : '0;
         zero_q   <= issue_legal && alu_zero;
      end else if (valid_q && bus.K_resp_ready) begin
         valid_q  <= 1'b0;
      end
   end

   assign bus.K_gnt         = gnt;
   assign bus.K_resp_valid  = valid_q;
   assign bus.K_resp_id     = id_q;
   assign bus.K_resp_result = result_q;
   assign bus.K_resp_zero   = zero_q;
   assign bus.K_resp_err    = err_q;

endmodule

// File: tb/tb_k_alu_arbiter.sv
// Bench for k_alu_arbiter: directed scenarios followed by random traffic, all
// checked against a behavioural model of arbitration and the ALU.
module tb_k_alu_arbiter;

   localparam int NREQ = 2;

   logic K_clk;
   logic K_reset;

   k_alu_arbiter_if #(.NREQ(NREQ)) bus ();

   k_alu_arbiter #(.NREQ(NREQ)) dut (
      .K_clk   (K_clk),
      .K_reset (K_reset),
      .bus     (bus)
   );

   initial K_clk = 1'b0;
   always #5 K_clk = ~K_clk;

   int errors = 0;
   int checks = 0;

   logic [NREQ-1:0] t_req;
   logic [3:0]      t_op [NREQ];
   logic [31:0]     t_a  [NREQ];
   logic [31:0]     t_b  [NREQ];
   logic [4:0]      t_sh [NREQ];

   logic        m_valid;
   int          m_id;
   int          m_ptr;
   logic [31:0] m_result;
   logic        m_zero;
   logic        m_err;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
      end
   endtask

   function automatic void refAlu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] sh, output logic [31:0] r, output logic z,
                                  output logic e);
      e = 1'b0;
      case (op)
         4'd0:    r = a & b;
         4'd1:    r = a | b;
         4'd2:    r = a + b;
         4'd6:    r = a - b;
         4'd7:    r = (a < b) ? 32'd1 : 32'd0;
         4'd8:    r = b << sh;
         default: begin r = 32'd0; e = 1'b1; end
      endcase
      z = e ? 1'b0 : (r == 32'd0);
   endfunction

   task automatic setReq(input int r, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh);
      t_req[r] = 1'b1;
      t_op[r]  = op;
      t_a[r]   = a;
      t_b[r]   = b;
      t_sh[r]  = sh;
   endtask

   // One clock: drive inputs, check grant/response against the model, advance model.
   task automatic applyStimulus(input logic rst, input logic rdy, output logic [NREQ-1:0] g);
      int acc;
      int idx;
      logic [NREQ-1:0] exp_gnt;
      bus.K_req = t_req;
      for (int i = 0; i < NREQ; i++) begin
         bus.K_op[4*i +: 4]     = t_op[i];
         bus.K_a[32*i +: 32]    = t_a[i];
         bus.K_b[32*i +: 32]    = t_b[i];
         bus.K_shamt[5*i +: 5]  = t_sh[i];
      end
      bus.K_resp_ready = rdy;
      K_reset = rst;
      #4;
      acc = -1;
      exp_gnt = '0;
      if (!rst && (!m_valid || rdy)) begin
         for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (acc < 0 && t_req[idx]) acc = idx;
         end
      end
      if (acc >= 0) exp_gnt[acc] = 1'b1;
      g = bus.K_gnt;
      checkOutput("gnt", 32'(bus.K_gnt), 32'(exp_gnt));
      checkOutput("resp_valid", 32'(bus.K_resp_valid), 32'(m_valid));
      if (m_valid) begin
         checkOutput("resp_id", 32'(bus.K_resp_id), 32'(m_id));
         checkOutput("resp_result", bus.K_resp_result, m_result);
         checkOutput("resp_zero", 32'(bus.K_resp_zero), 32'(m_zero));
         checkOutput("resp_err", 32'(bus.K_resp_err), 32'(m_err));
      end
      @(posedge K_clk);
      #1;
      if (rst) begin
         m_valid = 1'b0; m_id = 0; m_ptr = 0;
         m_result = '0; m_zero = 1'b0; m_err = 1'b0;
      end else if (acc >= 0) begin
         refAlu(t_op[acc], t_a[acc], t_b[acc], t_sh[acc], m_result, m_zero, m_err);
         m_valid = 1'b1;
         m_id = acc;
         m_ptr = (acc + 1) % NREQ;
         t_req[acc] = 1'b0;
      end else if (m_valid && rdy) begin
         m_valid = 1'b0;
      end
      K_reset = 1'b0;
   endtask

   logic [NREQ-1:0] g;
   logic [3:0] codes [8];

   initial begin
      codes = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd8, 4'd5, 4'd15};
      t_req = '0;
      for (int i = 0; i < NREQ; i++) begin
         t_op[i] = '0; t_a[i] = '0; t_b[i] = '0; t_sh[i] = '0;
      end
      bus.K_req = '0; bus.K_op = '0; bus.K_a = '0; bus.K_b = '0; bus.K_shamt = '0;
      bus.K_resp_ready = 1'b1;
      K_reset = 1'b1;
      repeat (2) @(posedge K_clk);
      #1;
      K_reset = 1'b0;
      m_valid = 1'b0; m_id = 0; m_ptr = 0; m_result = '0; m_zero = 1'b0; m_err = 1'b0;

      checkOutput("rst_valid", 32'(bus.K_resp_valid), 32'd0);
      checkOutput("rst_id", 32'(bus.K_resp_id), 32'd0);
      checkOutput("rst_result", bus.K_resp_result, 32'd0);
      checkOutput("rst_zero", 32'(bus.K_resp_zero), 32'd0);
      checkOutput("rst_err", 32'(bus.K_resp_err), 32'd0);

      $display("[TB] test 1: single ADD");
      setReq(0, 4'd2, 32'd5, 32'd7, 5'd0);
      applyStimulus(1'b0, 1'b1, g);
      checkOutput("t1_gnt", 32'(g), 32'd1);
      checkOutput("t1_valid", 32'(bus.K_resp_valid), 32'd1);
      checkOutput("t1_result", bus.K_resp_result, 32'd12);
      checkOutput("t1_zero", 32'(bus.K_resp_zero), 32'd0);
      checkOutput("t1_id", 32'(bus.K_resp_id), 32'd0);
      checkOutput("t1_err", 32'(bus.K_resp_err), 32'd0);

      $display("[TB] test 2: alternating grants");
      applyStimulus(1'b1, 1'b1, g);
      for (int k = 0; k < 4; k++) begin
         setReq(0, 4'd2, 32'(k), 32'd100, 5'd0);
         setReq(1, 4'd1, 32'(k), 32'h100, 5'd0);
         applyStimulus(1'b0, 1'b1, g);
         checkOutput("t2_gnt", 32'(g), 32'(1 << (k % 2)));
         checkOutput("t2_tag", 32'(bus.K_resp_id), 32'(k % 2));
         checkOutput("t2_valid", 32'(bus.K_resp_valid), 32'd1);
      end
      t_req = '0;
      applyStimulus(1'b0, 1'b1, g);

      $display("[TB] test 3: SUB and SLT");
      setReq(1, 4'd6, 32'd9, 32'd9, 5'd0);
      applyStimulus(1'b0, 1'b1, g);
      checkOutput("t3_sub_result", bus.K_resp_result, 32'd0);
      checkOutput("t3_sub_zero", 32'(bus.K_resp_zero), 32'd1);
      setReq(1, 4'd7, 32'd3, 32'd4, 5'd0);
      applyStimulus(1'b0, 1'b1, g);
      checkOutput("t3_slt_lt", bus.K_resp_result, 32'd1);
      setReq(1, 4'd7, 32'd4, 32'd3, 5'd0);
      applyStimulus(1'b0, 1'b1, g);
      checkOutput("t3_slt_ge", bus.K_resp_result, 32'd0);
      checkOutput("t3_slt_ge_zero", 32'(bus.K_resp_zero), 32'd1);

      $display("[TB] test 4: SLL shamt-only change");
      setReq(0, 4'd8, 32'd0, 32'd1, 5'd4);
      applyStimulus(1'b0, 1'b1, g);
      checkOutput("t4_sll4", bus.K_resp_result, 32'd16);
      setReq(0, 4'd8, 32'd0, 32'd1, 5'd31);
      applyStimulus(1'b0, 1'b1, g);
      checkOutput("t4_sll31", bus.K_resp_result, 32'h8000_0000);

      $display("[TB] test 5: backpressure");
      setReq(0, 4'd1, 32'hF0, 32'h0F, 5'd0);
      applyStimulus(1'b0, 1'b1, g);
      setReq(0, 4'd2, 32'd1, 32'd1, 5'd0);
      setReq(1, 4'd2, 32'd2, 32'd2, 5'd0);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, 1'b0, g);
         checkOutput("t5_no_gnt", 32'(g), 32'd0);
         checkOutput("t5_hold_result", bus.K_resp_result, 32'hFF);
         checkOutput("t5_hold_id", 32'(bus.K_resp_id), 32'd0);
         checkOutput("t5_hold_valid", 32'(bus.K_resp_valid), 32'd1);
      end
      applyStimulus(1'b0, 1'b1, g);
      checkOutput("t5_regrant", 32'(g), 32'd2);
      checkOutput("t5_new_id", 32'(bus.K_resp_id), 32'd1);
      checkOutput("t5_new_result", bus.K_resp_result, 32'd4);
      t_req = '0;
      applyStimulus(1'b0, 1'b1, g);

      $display("[TB] test 6: illegal op and reset mid-stream");
      setReq(0, 4'd5, 32'd7, 32'd7, 5'd3);
      applyStimulus(1'b0, 1'b1, g);
      checkOutput("t6_err", 32'(bus.K_resp_err), 32'd1);
      checkOutput("t6_result", bus.K_resp_result, 32'd0);
      checkOutput("t6_zero", 32'(bus.K_resp_zero), 32'd0);
      checkOutput("t6_valid", 32'(bus.K_resp_valid), 32'd1);
      setReq(1, 4'd2, 32'd1, 32'd2, 5'd0);
      applyStimulus(1'b0, 1'b1, g);
      setReq(0, 4'd2, 32'd3, 32'd3, 5'd0);
      setReq(1, 4'd2, 32'd4, 32'd4, 5'd0);
      applyStimulus(1'b1, 1'b1, g);
      checkOutput("t6_rst_no_gnt", 32'(g), 32'd0);
      checkOutput("t6_rst_valid", 32'(bus.K_resp_valid), 32'd0);
      applyStimulus(1'b0, 1'b1, g);
      checkOutput("t6_first_gnt", 32'(g), 32'd1);

      $display("[TB] random traffic");
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!t_req[i] && ($urandom_range(0, 1) == 1)) begin
               logic [31:0] ra;
               logic [31:0] rb;
               ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
               rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
               setReq(i, codes[$urandom_range(0, 7)], ra, rb, 5'($urandom_range(0, 31)));
            end
         end
         applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), g);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
